// File: rtl/ctl_charlieplex_scroll.sv
// Scrolls a stream of 5-pixel columns across a 7x5 charlieplexed screen by
// rewriting the peripheral's five row registers over Wishbone on every step.
module ctl_charlieplex_scroll #(
  parameter int TicksPerStep = 1000000,
  parameter int FifoDepth    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic       wb_we_o,
  output logic [3:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_stb_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  output logic       empty_o
);

  localparam int PtrW  = $clog2(FifoDepth);
  localparam int TickW = $clog2(TicksPerStep);
  localparam logic [TickW-1:0] TickLast = TickW'(TicksPerStep - 1);
  localparam logic [PtrW:0]    FifoFull = (PtrW + 1)'(FifoDepth);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

  state_t             state_reg, state_next;
  logic               pending_reg, pending_next;
  logic [2:0]         row_reg, row_next;
  logic [TickW-1:0]   tick_reg;
  logic [6:0][4:0]    win_reg;
  logic [4:0]         mem [FifoDepth];
  logic [PtrW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PtrW:0]      count_reg;
  logic               step, push, pop, full, empty;
  logic [4:0]         head;
  logic [6:0]         row_bits;
  logic               unused_rd;

  assign unused_rd = ^wb_dat_i;

  assign full  = (count_reg == FifoFull);
  assign empty = (count_reg == '0);
  assign push  = s_valid_i && !full;
  assign pop   = (state_reg == SHIFT) && !empty;
  assign head  = empty ? 5'b0 : mem[rd_ptr_reg];
  assign step  = (tick_reg == TickLast);

  assign s_ready_o = !full;
  assign empty_o   = empty;

  // FIFO storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= s_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_reg    <= '0;
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
      row_reg     <= '0;
      win_reg     <= '0;
    end else begin
      tick_reg    <= step ? '0 : tick_reg + 1'b1;
      state_reg   <= state_next;
      pending_reg <= pending_next;
      row_reg     <= row_next;
      if (state_reg == SHIFT) win_reg <= {head, win_reg[6:1]};
    end
  end

  // A step that lands while busy is remembered once; extra ones are dropped.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    row_next     = row_reg;
    case (state_reg)
      IDLE: begin
        if (step || pending_reg) begin
          state_next   = SHIFT;
          pending_next = 1'b0;
        end
      end
      SHIFT: begin
        if (step) pending_next = 1'b1;
        row_next   = '0;
        state_next = WRITE;
      end
      WRITE: begin
        if (step) pending_next = 1'b1;
        if (wb_ack_i) begin
          if (row_reg == 3'd4) state_next = IDLE;
          else                 row_next   = row_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_row_bits
      assign row_bits[gi] = win_reg[gi][row_reg];
    end
  endgenerate

  assign wb_stb_o = (state_reg == WRITE);
  assign wb_we_o  = wb_stb_o;
  assign wb_adr_o = wb_stb_o ? {1'b0, row_reg} : 4'd0;
  assign wb_dat_o = wb_stb_o ? {1'b0, row_bits} : 8'd0;

endmodule

// File: tb/tb_ctl_charlieplex_scroll.sv
// Directed bench for ctl_charlieplex_scroll: 8-cycle steps, 4-entry FIFO,
// Wishbone ack tied to strobe unless deliberately stalled.
module tb_ctl_charlieplex_scroll;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       wb_we;
  logic [3:0] wb_adr;
  logic [7:0] wb_dat;
  logic       wb_stb;
  logic [7:0] wb_rdat;
  logic       wb_ack;
  logic       empty;
  logic       stall;

  int n_assert = 0;
  int n_fail   = 0;

  ctl_charlieplex_scroll #(.TicksPerStep(8), .FifoDepth(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .s_data_i (s_data),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .wb_we_o  (wb_we),
    .wb_adr_o (wb_adr),
    .wb_dat_o (wb_dat),
    .wb_stb_o (wb_stb),
    .wb_dat_i (wb_rdat),
    .wb_ack_i (wb_ack),
    .empty_o  (empty)
  );

  always #5 clk = ~clk;

  assign wb_ack = wb_stb & ~stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the strobe of the next row-0 write.
  task automatic wait_stb(output int n);
    n = 0;
    while (!wb_stb && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("stb_seen", {31'b0, wb_stb}, 32'd1);
  endtask

  task automatic collect(input string tag, input logic [7:0] exp [5], output int n);
    wait_stb(n);
    for (int r = 0; r < 5; r++) begin
      check({tag, "_adr"}, {28'b0, wb_adr}, r);
      check({tag, "_dat"}, {24'b0, wb_dat}, {24'b0, exp[r]});
      check({tag, "_we"},  {31'b0, wb_we}, 32'd1);
      $display("step %s row %0d adr %0d dat 0x%02h", tag, r, wb_adr, wb_dat);
      @(negedge clk);
    end
    check({tag, "_idle"}, {31'b0, wb_stb}, 32'd0);
  endtask

  task automatic skip_steps(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      wait_stb(n);
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin
    int         n;
    logic [7:0] v;
    logic [4:0] cols [5];

    rst = 1'b1; s_valid = 1'b0; s_data = '0; stall = 1'b0; wb_rdat = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ready", {31'b0, s_ready}, 32'd1);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_stb",   {31'b0, wb_stb}, 32'd0);
    check("rst_we",    {31'b0, wb_we}, 32'd0);
    check("rst_adr",   {28'b0, wb_adr}, 32'd0);
    check("rst_dat",   {24'b0, wb_dat}, 32'd0);
    rst = 1'b0;

    collect("first", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n);
    check("first_latency", n, 32'd9);

    // Single column scrolls from col 6 down to col 0 and out
    s_data = 5'b10101; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("single_empty", {31'b0, empty}, 32'd0);
    collect("single0", '{8'h40, 8'h00, 8'h40, 8'h00, 8'h40}, n);
    for (int k = 1; k <= 6; k++) begin
      v = 8'h40 >> k;
      collect("single_scroll", '{v, 8'h00, v, 8'h00, v}, n);
    end
    collect("single_out", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n);

    // Ack stall: outputs hold, one pending step afterwards
    stall = 1'b1;
    s_data = 5'b00001; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    wait_stb(n);
    for (int j = 1; j <= 27; j++) begin
      check("stall_stb", {31'b0, wb_stb}, 32'd1);
      check("stall_adr", {28'b0, wb_adr}, 32'd0);
      check("stall_dat", {24'b0, wb_dat}, 32'h40);
      if (j < 27) @(negedge clk);
    end
    $display("stall held 27 cycles adr %0d dat 0x%02h", wb_adr, wb_dat);
    stall = 1'b0;
    for (int r = 1; r < 5; r++) begin
      @(negedge clk);
      check("stall_rel_adr", {28'b0, wb_adr}, r);
      check("stall_rel_dat", {24'b0, wb_dat}, 32'd0);
    end
    @(negedge clk);
    check("stall_rel_idle", {31'b0, wb_stb}, 32'd0);
    @(negedge clk);
    check("stall_rel_shift", {31'b0, wb_stb}, 32'd0);
    collect("pending", '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, n);
    check("pending_latency", n, 32'd1);
    collect("after_pending", '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, n);
    check("after_pending_latency", n, 32'd2);
    collect("no_second_pending", '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00}, n);
    check("no_second_latency", n, 32'd3);

    // FIFO full: four accepted, fifth held until a pop frees a slot
    cols = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      s_data = cols[i]; s_valid = 1'b1;
      @(negedge clk);
    end
    check("full_ready", {31'b0, s_ready}, 32'd0);
    check("full_empty", {31'b0, empty}, 32'd0);
    s_data = cols[4];
    n = 0;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("full_release_wait", n, 32'd4);
    $display("fifth column accepted after %0d cycles", n);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    skip_steps(3);
    check("full_drain_empty", {31'b0, empty}, 32'd0);
    collect("full_order", '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40}, n);
    check("full_done_empty", {31'b0, empty}, 32'd1);

    // Push in the SHIFT cycle with one entry queued
    s_data = 5'b11111; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    check("pp_before_empty", {31'b0, empty}, 32'd0);
    s_data = 5'b10000; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("pp_after_empty", {31'b0, empty}, 32'd0);
    collect("pp_first", '{8'h42, 8'h44, 8'h48, 8'h50, 8'h60}, n);
    collect("pp_second", '{8'h21, 8'h22, 8'h24, 8'h28, 8'h70}, n);
    check("pp_final_empty", {31'b0, empty}, 32'd1);

    // Asynchronous reset during row 2 write
    s_data = 5'b01110; s_valid = 1'b1;
    @(negedge clk);
    s_data = 5'b00100;
    @(negedge clk);
    s_valid = 1'b0;
    wait_stb(n);
    repeat (2) @(negedge clk);
    check("arst_row", {28'b0, wb_adr}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_stb",   {31'b0, wb_stb}, 32'd0);
    check("arst_we",    {31'b0, wb_we}, 32'd0);
    check("arst_adr",   {28'b0, wb_adr}, 32'd0);
    check("arst_dat",   {24'b0, wb_dat}, 32'd0);
    check("arst_empty", {31'b0, empty}, 32'd1);
    check("arst_ready", {31'b0, s_ready}, 32'd1);
    $display("async reset mid-write stb %0d empty %0d", wb_stb, empty);
    @(negedge clk);
    rst = 1'b0;
    check("arst_idle", {31'b0, wb_stb}, 32'd0);
    collect("arst_next", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n);
    check("arst_latency", n, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
